// File: rtl/conv3x3_filter.sv
// conv3x3_filter: three-stage 3x3 window filter (bypass, box, gaussian, sobel)
// for 4-bit pixels. The filter mode is latched once per frame, on the window at
// (0,0). That mode travels down the pipeline with each window, so every pixel of
// a frame is filtered with the same mode. Output column and row indices come from
// a second counter, which advances only on valid output pixels.
module conv3x3_filter #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [35:0] win_in,
    input  logic        win_valid,
    input  logic [1:0]  mode,
    output logic [3:0]  pix_out,
    output logic        pix_valid,
    output logic        sof,
    output logic        eof,
    output logic [8:0]  col_out,
    output logic [7:0]  row_out
);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_BOX    = 2'd1,
        MODE_GAUSS  = 2'd2,
        MODE_SOBEL  = 2'd3
    } mode_e;

    localparam logic [8:0] LAST_COL = 9'(IMG_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);

    logic [8:0]  r_in_col;
    logic [7:0]  r_in_row;
    logic [1:0]  r_active_mode;
    logic        w_frame_start;
    logic [1:0]  w_win_mode;

    logic        r_s1_valid;
    logic [35:0] r_s1_win;
    logic [1:0]  r_s1_mode;

    logic        r_s2_valid;
    logic [3:0]  r_s2_pix;

    logic [8:0]  r_out_col_nxt;
    logic [7:0]  r_out_row_nxt;
    logic [3:0]  r_pix_out;
    logic        r_pix_valid;
    logic        r_sof;
    logic        r_eof;
    logic [8:0]  r_col_out;
    logic [7:0]  r_row_out;

    logic [3:0]  w_p0, w_p1, w_p2, w_p3, w_p4, w_p5, w_p6, w_p7, w_p8;
    logic [7:0]  w_box_sum;
    logic [12:0] w_box_prod;
    logic [3:0]  w_box_pix;
    logic [7:0]  w_gauss_sum;
    logic [3:0]  w_gauss_pix;
    logic [7:0]  w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [7:0] w_gx, w_gy;
    logic [7:0]  w_gx_abs, w_gy_abs;
    logic [7:0]  w_mag;
    logic [4:0]  w_mag_shr;
    logic [3:0]  w_sobel_pix;
    logic [3:0]  w_s2_pix;

    // The window at (0,0) uses the mode presented with it, not the stale latch.
    assign w_frame_start = (r_in_col == 9'd0) && (r_in_row == 8'd0);
    assign w_win_mode    = (win_valid && w_frame_start) ? mode : r_active_mode;

    // Input position counter and per-frame mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_col      <= 9'd0;
            r_in_row      <= 8'd0;
            r_active_mode <= 2'd0;
        end else if (win_valid) begin
            if (w_frame_start)
                r_active_mode <= mode;
            if (r_in_col == LAST_COL) begin
                r_in_col <= 9'd0;
                r_in_row <= (r_in_row == LAST_ROW) ? 8'd0 : r_in_row + 8'd1;
            end else begin
                r_in_col <= r_in_col + 9'd1;
            end
        end
    end

    // Stage 1: capture the window together with the mode of its frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_win   <= 36'd0;
            r_s1_mode  <= 2'd0;
        end else begin
            r_s1_valid <= win_valid;
            if (win_valid) begin
                r_s1_win  <= win_in;
                r_s1_mode <= w_win_mode;
            end
        end
    end

    assign w_p0 = r_s1_win[35:32];
    assign w_p1 = r_s1_win[31:28];
    assign w_p2 = r_s1_win[27:24];
    assign w_p3 = r_s1_win[23:20];
    assign w_p4 = r_s1_win[19:16];
    assign w_p5 = r_s1_win[15:12];
    assign w_p6 = r_s1_win[11:8];
    assign w_p7 = r_s1_win[7:4];
    assign w_p8 = r_s1_win[3:0];

    // Box: 57/512 approximates 1/9, and 135*57 still fits in 13 bits.
    assign w_box_sum  = {4'd0, w_p0} + {4'd0, w_p1} + {4'd0, w_p2}
                      + {4'd0, w_p3} + {4'd0, w_p4} + {4'd0, w_p5}
                      + {4'd0, w_p6} + {4'd0, w_p7} + {4'd0, w_p8};
    assign w_box_prod = {5'd0, w_box_sum} * 13'd57;
    assign w_box_pix  = 4'(w_box_prod >> 9);

    assign w_gauss_sum = {4'd0, w_p0}       + {3'd0, w_p1, 1'b0} + {4'd0, w_p2}
                       + {3'd0, w_p3, 1'b0} + {2'd0, w_p4, 2'b0} + {3'd0, w_p5, 1'b0}
                       + {4'd0, w_p6}       + {3'd0, w_p7, 1'b0} + {4'd0, w_p8};
    assign w_gauss_pix = 4'(w_gauss_sum >> 4);

    // Each partial sum is at most 60, so the signed 8-bit difference cannot wrap.
    assign w_gx_pos = {4'd0, w_p2} + {3'd0, w_p5, 1'b0} + {4'd0, w_p8};
    assign w_gx_neg = {4'd0, w_p0} + {3'd0, w_p3, 1'b0} + {4'd0, w_p6};
    assign w_gy_pos = {4'd0, w_p6} + {3'd0, w_p7, 1'b0} + {4'd0, w_p8};
    assign w_gy_neg = {4'd0, w_p0} + {3'd0, w_p1, 1'b0} + {4'd0, w_p2};
    assign w_gx     = signed'(w_gx_pos) - signed'(w_gx_neg);
    assign w_gy     = signed'(w_gy_pos) - signed'(w_gy_neg);
    assign w_gx_abs = w_gx[7] ? unsigned'(-w_gx) : unsigned'(w_gx);
    assign w_gy_abs = w_gy[7] ? unsigned'(-w_gy) : unsigned'(w_gy);
    assign w_mag    = w_gx_abs + w_gy_abs;
    assign w_mag_shr   = 5'(w_mag >> 3);
    assign w_sobel_pix = (w_mag_shr > 5'd15) ? 4'd15 : w_mag_shr[3:0];

    // Pick the filter result according to the mode carried with the window.
    always_comb begin
        w_s2_pix = w_p4;
        case (mode_e'(r_s1_mode))
            MODE_BYPASS: w_s2_pix = w_p4;
            MODE_BOX:    w_s2_pix = w_box_pix;
            MODE_GAUSS:  w_s2_pix = w_gauss_pix;
            MODE_SOBEL:  w_s2_pix = w_sobel_pix;
            default:     w_s2_pix = w_p4;
        endcase
    end

    // Stage 2: register the filtered pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_pix   <= 4'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_pix   <= r_s1_valid ? w_s2_pix : 4'd0;
        end
    end

    // Stage 3: output registers and output position counter; position holds on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_col_nxt <= 9'd0;
            r_out_row_nxt <= 8'd0;
            r_pix_out     <= 4'd0;
            r_pix_valid   <= 1'b0;
            r_sof         <= 1'b0;
            r_eof         <= 1'b0;
            r_col_out     <= 9'd0;
            r_row_out     <= 8'd0;
        end else if (r_s2_valid) begin
            r_pix_valid <= 1'b1;
            r_pix_out   <= r_s2_pix;
            r_col_out   <= r_out_col_nxt;
            r_row_out   <= r_out_row_nxt;
            r_sof       <= (r_out_col_nxt == 9'd0) && (r_out_row_nxt == 8'd0);
            r_eof       <= (r_out_col_nxt == LAST_COL) && (r_out_row_nxt == LAST_ROW);
            if (r_out_col_nxt == LAST_COL) begin
                r_out_col_nxt <= 9'd0;
                r_out_row_nxt <= (r_out_row_nxt == LAST_ROW) ? 8'd0 : r_out_row_nxt + 8'd1;
            end else begin
                r_out_col_nxt <= r_out_col_nxt + 9'd1;
            end
        end else begin
            r_pix_valid <= 1'b0;
            r_pix_out   <= 4'd0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end
    end

    assign pix_out   = r_pix_out;
    assign pix_valid = r_pix_valid;
    assign sof       = r_sof;
    assign eof       = r_eof;
    assign col_out   = r_col_out;
    assign row_out   = r_row_out;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter. The main instance uses an 8x4 image. A
// second 1x1 instance shares the same inputs and checks the case where frame
// start and frame end fall on the same pixel.
module tb_conv3x3_filter;

    localparam int W = 8;
    localparam int H = 4;

    localparam logic [35:0] ALL15  = 36'hFFF_FFF_FFF;
    localparam logic [35:0] COLR   = 36'h00F_00F_00F;
    localparam logic [35:0] COLL   = 36'hF00_F00_F00;
    localparam logic [35:0] TOPR   = 36'hFFF_000_000;
    localparam logic [35:0] CORNER = 36'h00F_00F_FFF;
    localparam logic [35:0] CTR8   = 36'h000_080_000;
    localparam logic [35:0] CTR5   = 36'h000_050_000;

    logic        clk;
    logic        rst_n;
    logic [35:0] win_in;
    logic        win_valid;
    logic [1:0]  mode;
    logic [3:0]  pix_out,  pix_out1;
    logic        pix_valid, pix_valid1;
    logic        sof, sof1, eof, eof1;
    logic [8:0]  col_out, col_out1;
    logic [7:0]  row_out, row_out1;

    conv3x3_filter #(.IMG_W(W), .IMG_H(H)) u_dut (
        .clk(clk), .rst_n(rst_n), .win_in(win_in), .win_valid(win_valid), .mode(mode),
        .pix_out(pix_out), .pix_valid(pix_valid), .sof(sof), .eof(eof),
        .col_out(col_out), .row_out(row_out)
    );

    conv3x3_filter #(.IMG_W(1), .IMG_H(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .win_in(win_in), .win_valid(win_valid), .mode(mode),
        .pix_out(pix_out1), .pix_valid(pix_valid1), .sof(sof1), .eof(eof1),
        .col_out(col_out1), .row_out(row_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] pix;
        logic [3:0] pix1;
    } ent_t;

    ent_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";
    int    icol, irow, ocol, orow, lcol, lrow;
    logic [1:0] tb_mode;

    // Reference result for one window, computed directly from the filter definitions.
    function automatic logic [3:0] ref_pix(input logic [35:0] w, input logic [1:0] md);
        int p[9];
        int s, g, gx, gy, m;
        for (int i = 0; i < 9; i++) p[i] = int'(w[35 - 4*i -: 4]);
        s  = p[0] + p[1] + p[2] + p[3] + p[4] + p[5] + p[6] + p[7] + p[8];
        g  = p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8];
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        case (md)
            2'd0:    return 4'(p[4]);
            2'd1:    return 4'((s * 57) / 512);
            2'd2:    return 4'(g / 16);
            default: return (m / 8 > 15) ? 4'd15 : 4'(m / 8);
        endcase
    endfunction

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    task automatic check_out();
        ent_t e;
        logic [23:0] obs0, exp0, obs1, exp1;
        e = q.pop_front();
        if (e.v) begin
            exp0 = {1'b1, e.pix, 1'(ocol == 0 && orow == 0), 1'(ocol == W-1 && orow == H-1),
                    9'(ocol), 8'(orow)};
            lcol = ocol;
            lrow = orow;
            if (ocol == W-1) begin
                ocol = 0;
                orow = (orow == H-1) ? 0 : orow + 1;
            end else begin
                ocol = ocol + 1;
            end
            exp1 = {1'b1, e.pix1, 1'b1, 1'b1, 9'd0, 8'd0};
        end else begin
            exp0 = {1'b0, 4'd0, 1'b0, 1'b0, 9'(lcol), 8'(lrow)};
            exp1 = 24'd0;
        end
        obs0 = {pix_valid, pix_out, sof, eof, col_out, row_out};
        obs1 = {pix_valid1, pix_out1, sof1, eof1, col_out1, row_out1};
        n_tests++;
        assert (obs0 === exp0) else begin
            n_fail++;
            $error("FAIL %s main {v,pix,sof,eof,col,row} obs=%h exp=%h", phase, obs0, exp0);
        end
        n_tests++;
        assert (obs1 === exp1) else begin
            n_fail++;
            $error("FAIL %s img1x1 {v,pix,sof,eof,col,row} obs=%h exp=%h", phase, obs1, exp1);
        end
    endtask

    // One clock: drive a window (or bubble), then check the pixel due out now.
    // hand >= 0 gives a hand-computed expected pixel for the main instance.
    task automatic cycle(input logic v, input logic [35:0] w, input logic [1:0] m, input int hand);
        ent_t e;
        win_valid = v;
        win_in    = w;
        mode      = m;
        e.v    = v;
        e.pix  = 4'd0;
        e.pix1 = 4'd0;
        if (v) begin
            if (icol == 0 && irow == 0) tb_mode = m;
            e.pix  = (hand >= 0) ? 4'(hand) : ref_pix(w, tb_mode);
            e.pix1 = ref_pix(w, m);
            if (icol == W-1) begin
                icol = 0;
                irow = (irow == H-1) ? 0 : irow + 1;
            end else begin
                icol = icol + 1;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        ent_t e;
        logic [23:0] obs0, obs1;
        rst_n = 1'b0;
        #1;
        obs0 = {pix_valid, pix_out, sof, eof, col_out, row_out};
        obs1 = {pix_valid1, pix_out1, sof1, eof1, col_out1, row_out1};
        n_tests++;
        assert (obs0 === 24'd0) else begin
            n_fail++;
            $error("FAIL %s reset_main obs=%h exp=%h", phase, obs0, 24'd0);
        end
        n_tests++;
        assert (obs1 === 24'd0) else begin
            n_fail++;
            $error("FAIL %s reset_1x1 obs=%h exp=%h", phase, obs1, 24'd0);
        end
        win_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        e.v = 1'b0; e.pix = 4'd0; e.pix1 = 4'd0;
        q.push_back(e);
        q.push_back(e);
        icol = 0; irow = 0; ocol = 0; orow = 0; lcol = 0; lrow = 0;
        tb_mode = 2'd0;
    endtask

    initial begin
        logic [35:0] w;
        int sent;
        rst_n     = 1'b0;
        win_in    = 36'd0;
        win_valid = 1'b0;
        mode      = 2'd0;
        #2;
        do_reset();

        phase = "bypass";
        for (int i = 0; i < W*H; i++) begin
            w = rnd36();
            w[19:16] = 4'(i % 16);
            cycle(1'b1, w, 2'd0, i % 16);
        end

        phase = "box";
        cycle(1'b1, ALL15, 2'd1, 15);
        cycle(1'b1, COLR,  2'd1, 5);
        cycle(1'b1, CTR8,  2'd1, 0);
        for (int i = 3; i < W*H; i++) cycle(1'b1, rnd36(), (i >= 10) ? 2'd3 : 2'd1, -1);

        phase = "gauss";
        cycle(1'b1, ALL15, 2'd2, 15);
        cycle(1'b1, COLR,  2'd2, 3);
        cycle(1'b1, CTR8,  2'd2, 2);
        for (int i = 3; i < W*H; i++) cycle(1'b1, rnd36(), 2'd2, -1);

        phase = "sobel";
        cycle(1'b1, ALL15,  2'd3, 0);
        cycle(1'b1, COLR,   2'd3, 7);
        cycle(1'b0, ALL15,  2'd3, -1);
        cycle(1'b1, COLL,   2'd3, 7);
        cycle(1'b1, TOPR,   2'd3, 7);
        cycle(1'b1, CORNER, 2'd3, 11);
        for (int i = 5; i < W*H; i++) cycle(1'b1, rnd36(), 2'd3, -1);

        phase = "mode_latch";
        for (int i = 0; i < W*H; i++) cycle(1'b1, rnd36(), (i >= 10) ? 2'd2 : 2'd0, -1);
        cycle(1'b1, CTR8, 2'd2, 2);
        for (int i = 1; i < W*H; i++) cycle(1'b1, rnd36(), 2'd2, -1);

        phase = "bubbles";
        sent = 0;
        for (int k = 0; k < 1000 && sent < 2*W*H; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                cycle(1'b0, rnd36(), 2'd1, -1);
            end else begin
                cycle(1'b1, rnd36(), 2'd1, -1);
                sent++;
            end
        end
        n_tests++;
        assert (sent == 2*W*H) else begin
            n_fail++;
            $error("FAIL bubbles sent_windows obs=%0d exp=%0d", sent, 2*W*H);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 36'd0, 2'd1, -1);

        phase = "midreset";
        for (int i = 0; i < 12; i++) cycle(1'b1, rnd36(), 2'd3, -1);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, rnd36(), 2'd3, -1);
        cycle(1'b1, CTR5, 2'd0, 5);
        for (int i = 1; i < 5; i++) cycle(1'b1, rnd36(), 2'd0, -1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 36'd0, 2'd0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_filter.md
CONV3X3_FILTER -- requirements
Module: conv3x3_filter

Interface
REQ-001 Parameter IMG_W, default 320, image width in pixels (output column count per line).
REQ-002 Parameter IMG_H, default 240, image height in lines (output line count per frame).
REQ-003 Reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 win_in  input  36  3x3 window of 4-bit pixels, zero-padded at borders; [35:32]=r0c0, [31:28]=r0c1, [27:24]=r0c2, [23:20]=r1c0, [19:16]=r1c1 (centre), [15:12]=r1c2, [11:8]=r2c0, [7:4]=r2c1, [3:0]=r2c2; row 0 is the oldest line.
REQ-007 win_valid  input  1  win_in is valid this cycle; may deassert for any number of cycles (bubbles).
REQ-008 mode  input  2  filter select: 0 bypass, 1 box, 2 gaussian, 3 sobel.
REQ-009 pix_out  output  4  filtered pixel.
REQ-010 pix_valid  output  1  pix_out is valid this cycle.
REQ-011 sof  output  1  start of frame; high with the pixel at column 0, row 0.
REQ-012 eof  output  1  end of frame; high with the pixel at column IMG_W-1, row IMG_H-1.
REQ-013 col_out  output  9  column index of pix_out.
REQ-014 row_out  output  8  row index of pix_out.

Function
REQ-015 Pipeline: exactly 3 registered stages; a window accepted at cycle N produces pix_valid=1 at cycle N+3.
REQ-016 Bubbles: a cycle with win_valid=0 propagates as pix_valid=0; the pipeline never stalls or drops a valid window.
REQ-017 Input counter (in_col, in_row) counts accepted windows; in_col wraps at IMG_W-1 and then increments in_row; in_row wraps at IMG_H-1 to 0.
REQ-018 Mode latch: active_mode loads mode only when win_valid=1 and in_col=0, in_row=0; mode changes mid-frame are ignored until the next frame start.
REQ-019 The latched mode travels with each window through the pipeline, so every pixel of a frame uses that frame's mode.
REQ-020 Mode 0: pix_out = centre pixel r1c1.
REQ-021 Mode 1: S = unsigned sum of all 9 pixels (8 bits, max 135); pix_out = (S*57)>>9 (13-bit product); 135 gives 15.
REQ-022 Mode 2: weights 1-2-1/2-4-2/1-2-1; G = weighted sum (8 bits, max 240); pix_out = G>>4.
REQ-023 Mode 3: Gx = (r0c2+2*r1c2+r2c2)-(r0c0+2*r1c0+r2c0) and Gy = (r2c0+2*r2c1+r2c2)-(r0c0+2*r0c1+r0c2), each signed 7-bit; M = |Gx|+|Gy| (7-bit unsigned, max 120); pix_out = min(15, M>>3).
REQ-024 Every arithmetic intermediate is wide enough that it never overflows; the final result saturates at 15 and never wraps.
REQ-025 Output counter (col_out, row_out) follows the same wrap rules as REQ-017 and advances only on cycles with pix_valid=1.
REQ-026 sof and eof are high only on cycles with pix_valid=1 and are derived from the output counter.
REQ-027 When pix_valid=0, pix_out, sof and eof are 0; col_out and row_out hold their values.
REQ-028 For IMG_W=1 or IMG_H=1 the frame-start and frame-end positions coincide, so sof and eof are high on the same pixel.

Reset
REQ-029 On rst_n=0: all pipeline valid bits, pix_out, pix_valid, sof, eof, col_out, row_out and the input counters go to 0, and active_mode goes to 0 (bypass).
REQ-030 Reset asserted mid-frame discards all in-flight windows; after release the first accepted window is treated as column 0, row 0 of a new frame.

Verification
REQ-031 Bypass: mode=0, frame of windows with centre = (index mod 16) -> each pix_out equals its centre, 3 cycles later; sof at (0,0); eof at (319,239).
REQ-032 Arithmetic: all pixels 15 -> box 15, gaussian 15, sobel 0; left column 0 and right column 15 -> sobel Gx=60, pix_out=7.
REQ-033 Mode latch: switch mode 0->2 at window 100 of a frame -> that frame stays bypass; the next frame is gaussian from pixel (0,0).
REQ-034 Bubbles: win_valid toggles 1,0,0,1 randomly over a full frame -> output count = 76800, order preserved, single sof/eof, counters wrap to (0,0).
REQ-035 Reset: assert rst_n=0 at window 5000 with 3 windows in flight -> no pix_valid after reset; the next window yields sof=1, col_out=0, row_out=0.
